// File: rtl/sdram_pkg.sv
// Shared constants and state type for the SDRAM front-end arbiter.
package sdram_pkg;

    localparam int AVM_DW  = 16;
    localparam int AVM_AW  = 32;
    localparam int AVM_BEW = AVM_DW / 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sync_id_fifo.sv
// Synchronous FIFO that remembers which requester owns each outstanding read.
// A pop and a push in the same cycle are both honoured even when full, so
// the count is unchanged in that case.
module sync_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pop first, so a full FIFO can still take a push in the same cycle.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy guards them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that merges several Avalon-MM masters onto one SDRAM
// controller port and steers returning read data back to its owner.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no grant; all requesters stalled, winner chosen if any active
//   ST_GRANT | winner's command bus forwarded downstream until release
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAXOUT  = 16,
    parameter int HOLDMAX = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NREQ-1:0]                    rq_read,
    input  logic [NREQ-1:0]                    rq_write,
    input  logic [NREQ-1:0][AVM_AW-1:0]        rq_address,
    input  logic [NREQ-1:0][AVM_DW-1:0]        rq_writedata,
    input  logic [NREQ-1:0][AVM_BEW-1:0]       rq_byteenable,
    output logic [NREQ-1:0]                    rq_waitrequest,
    output logic [AVM_DW-1:0]                  rq_readdata,
    output logic [NREQ-1:0]                    rq_readdatavalid,
    output logic                               avm_m0_read,
    output logic                               avm_m0_write,
    output logic [AVM_AW-1:0]                  avm_m0_address,
    output logic [AVM_DW-1:0]                  avm_m0_writedata,
    output logic [AVM_BEW-1:0]                 avm_m0_byteenable,
    input  logic [AVM_DW-1:0]                  avm_m0_readdata,
    input  logic                               avm_m0_readdatavalid,
    input  logic                               avm_m0_waitrequest,
    output logic                               err_underflow
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAXOUT) + 1;
    localparam int HW  = $clog2(HOLDMAX) + 1;

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] winner_q, winner_d;
    logic [IDW-1:0] last_winner_q, last_winner_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic           err_q, err_d;

    logic [NREQ-1:0] active;
    logic            win_rd, win_wr;
    logic            block;
    logic            accept;

    logic            fifo_push, fifo_pop;
    logic [IDW-1:0]  fifo_head;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    // First active index strictly after 'last', wrapping around.
    function automatic logic [IDW-1:0] rr_next(input logic [NREQ-1:0] act,
                                               input logic [IDW-1:0] last);
        logic [IDW-1:0] pick;
        logic           found;
        int             k;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            k = (32'(last) + i) % NREQ;
            if (!found && act[k[IDW-1:0]]) begin
                found = 1'b1;
                pick  = k[IDW-1:0];
            end
        end
        return pick;
    endfunction

    assign active = rq_read | rq_write;
    assign win_rd = rq_read[winner_q];
    assign win_wr = rq_write[winner_q];

    // Next-state, command forwarding and stall generation.
    always_comb begin
        state_d           = state_q;
        winner_d          = winner_q;
        last_winner_d     = last_winner_q;
        hold_cnt_d        = hold_cnt_q;
        block             = 1'b0;
        accept            = 1'b0;
        avm_m0_read       = 1'b0;
        avm_m0_write      = 1'b0;
        avm_m0_address    = rq_address[winner_q];
        avm_m0_writedata  = rq_writedata[winner_q];
        avm_m0_byteenable = rq_byteenable[winner_q];
        rq_waitrequest    = '1;

        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    winner_d   = rr_next(active, last_winner_q);
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                block        = win_rd && (fifo_count == CW'(MAXOUT));
                avm_m0_read  = win_rd && !block;
                // Read wins when a master illegally asserts both.
                avm_m0_write = win_wr && !win_rd;
                rq_waitrequest[winner_q] = avm_m0_waitrequest | block;
                accept = (avm_m0_read || avm_m0_write) && !avm_m0_waitrequest;
                if (!(win_rd || win_wr)) begin
                    state_d       = ST_IDLE;
                    last_winner_d = winner_q;
                    hold_cnt_d    = '0;
                end else if (accept) begin
                    if (hold_cnt_q == HW'(HOLDMAX - 1)) begin
                        state_d       = ST_IDLE;
                        last_winner_d = winner_q;
                        hold_cnt_d    = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The registered state may still read GRANT during the reset cycle.
        if (reset) begin
            avm_m0_read    = 1'b0;
            avm_m0_write   = 1'b0;
            rq_waitrequest = '1;
            accept         = 1'b0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            winner_q      <= '0;
            last_winner_q <= IDW'(NREQ - 1);
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            last_winner_q <= last_winner_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign fifo_push = accept && avm_m0_read;
    assign fifo_pop  = avm_m0_readdatavalid && !fifo_empty && !reset;

    sync_id_fifo #(
        .W     (IDW),
        .DEPTH (MAXOUT)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (winner_q),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rq_readdata = avm_m0_readdata;

    // Steer the read strobe to the owner at the head of the ID FIFO.
    always_comb begin
        rq_readdatavalid = '0;
        if (fifo_pop) rq_readdatavalid[fifo_head] = 1'b1;
    end

    assign err_d = err_q | (avm_m0_readdatavalid && fifo_empty);

    // Sticky underflow flag: data returned with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_underflow = err_q;

endmodule
